// File: rtl/adder_1_pkg.sv
// adder_1_pkg: shared constants, result type and half-add helper for adder_1
package adder_1_pkg;
  localparam int CNT_W_DEFAULT = 8;
  typedef struct packed {
    logic c;
    logic s;
  } ha_t;
  function automatic ha_t half_add(input logic a, input logic b);
    return '{c: a & b, s: a ^ b};
  endfunction
endpackage

// File: rtl/adder_1_core.sv
// adder_1_core: combinational half adder (a, b -> s = a^b, c = a&b)
module adder_1_core
  import adder_1_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  ha_t r;
  assign r = half_add(a, b);
  assign s = r.s;
  assign c = r.c;
endmodule

// File: rtl/adder_1.sv
// adder_1: half adder (a,b -> s,c) with registered copy (s_q,c_q,vld_q on en) and saturating carry count (carry_cnt,cnt_sat; clr clears)
module adder_1
  import adder_1_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic             clr,
  output logic             s,
  output logic             c,
  output logic             s_q,
  output logic             c_q,
  output logic             vld_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             cnt_sat
);
  adder_1_core u_core (.a(a), .b(b), .s(s), .c(c));
  assign cnt_sat = &carry_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_q       <= 1'b0;
      c_q       <= 1'b0;
      vld_q     <= 1'b0;
      carry_cnt <= '0;
    end else begin
      vld_q     <= en;
      s_q       <= en ? s : s_q;
      c_q       <= en ? c : c_q;
      carry_cnt <= clr ? '0 : (en && c && !cnt_sat) ? carry_cnt + CNT_W'(1) : carry_cnt;
    end
endmodule

// File: tb/tb_adder_1.sv
// tb_adder_1: scoreboard bench for adder_1 at CNT_W=8 and CNT_W=2 against an integer reference model
module tb_adder_1;
  logic clk = 1'b0, clk_on = 1'b0, rst = 1'b0;
  logic a = 1'b0, b = 1'b0, en = 1'b0, clr = 1'b0;
  logic s, c, s_q, c_q, vld_q, cnt_sat, s2, c2, s_q2, c_q2, vld_q2, cnt_sat2;
  logic [7:0] carry_cnt;
  logic [1:0] carry_cnt2;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic s, c, sq, cq, v;
    int   n8, n2;
  } exp_t;
  exp_t q[$];
  logic m_sq = 1'b0, m_cq = 1'b0;
  int   m_n8 = 0, m_n2 = 0;
  adder_1 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .clr(clr), .s(s), .c(c),
    .s_q(s_q), .c_q(c_q), .vld_q(vld_q), .carry_cnt(carry_cnt), .cnt_sat(cnt_sat)
  );
  adder_1 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .clr(clr), .s(s2), .c(c2),
    .s_q(s_q2), .c_q(c_q2), .vld_q(vld_q2), .carry_cnt(carry_cnt2), .cnt_sat(cnt_sat2)
  );
  always #5 if (clk_on) clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic ia, input logic ib, input logic ien, input logic iclr);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; en = ien; clr = iclr;
    e.s = (int'(ia) + int'(ib)) % 2;
    e.c = (int'(ia) + int'(ib)) / 2;
    if (ien) begin
      m_sq = e.s;
      m_cq = e.c;
    end
    if (iclr) begin
      m_n8 = 0;
      m_n2 = 0;
    end else if (ien && e.c) begin
      m_n8 = (m_n8 + 1 > 255) ? 255 : m_n8 + 1;
      m_n2 = (m_n2 + 1 > 3) ? 3 : m_n2 + 1;
    end
    e.sq = m_sq; e.cq = m_cq; e.v = ien; e.n8 = m_n8; e.n2 = m_n2;
    q.push_back(e);
  endtask
  task automatic chk_regs_zero(input string tag);
    chk({tag, " s_q"}, 32'(s_q), 0);
    chk({tag, " c_q"}, 32'(c_q), 0);
    chk({tag, " vld_q"}, 32'(vld_q), 0);
    chk({tag, " carry_cnt"}, 32'(carry_cnt), 0);
    chk({tag, " cnt_sat"}, 32'(cnt_sat), 0);
    chk({tag, " carry_cnt2"}, 32'(carry_cnt2), 0);
    chk({tag, " cnt_sat2"}, 32'(cnt_sat2), 0);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("s", 32'(s), 32'(e.s));
      chk("c", 32'(c), 32'(e.c));
      chk("s_q", 32'(s_q), 32'(e.sq));
      chk("c_q", 32'(c_q), 32'(e.cq));
      chk("vld_q", 32'(vld_q), 32'(e.v));
      chk("carry_cnt", 32'(carry_cnt), 32'(e.n8));
      chk("cnt_sat", 32'(cnt_sat), 32'(e.n8 == 255));
      chk("s_q2", 32'(s_q2), 32'(e.sq));
      chk("carry_cnt2", 32'(carry_cnt2), 32'(e.n2));
      chk("cnt_sat2", 32'(cnt_sat2), 32'(e.n2 == 3));
    end
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      a = i[1]; b = i[0];
      #10;
      chk("idle s", 32'(s), 32'((i[1] + i[0]) % 2));
      chk("idle c", 32'(c), 32'((i[1] + i[0]) / 2));
      chk("idle s2", 32'(s2), 32'((i[1] + i[0]) % 2));
    end
    rst = 1'b1;
    #5;
    chk_regs_zero("reset");
    rst = 1'b0;
    clk_on = 1'b1;
    repeat (3) step(1, 1, 1, 0);
    step(0, 1, 0, 0);
    repeat (2) step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    repeat (2) step(1, 1, 1, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_regs_zero("async rst");
    a = 1'b0; b = 1'b1;
    #1;
    chk("rst s", 32'(s), 1);
    chk("rst c", 32'(c), 0);
    rst = 1'b0;
    m_sq = 1'b0; m_cq = 1'b0; m_n8 = 0; m_n2 = 0;
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    repeat (200) step(1'($urandom), 1'($urandom), $urandom_range(3) != 0, $urandom_range(15) == 0);
    repeat (260) step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    repeat (200) step(1'($urandom), 1'($urandom), $urandom_range(3) != 0, $urandom_range(31) == 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
